powlib_srrarb: RTL and testbench

- Synchronous N-way round-robin arbiter that merges N valid/ready streams into one registered output stream.
- Sits directly upstream of the synchronous FIFO and drives its write port (wrdata/wrvld/wrrdy).
- Multiple producers can therefore share one FIFO.
- Full throughput: one transfer per cycle; one cycle of latency.

---
 rtl/powlib_srrarb.sv | 111 +++++++++++
 tb/tb_powlib_srrarb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/powlib_srrarb.sv
// N-way round-robin arbiter merging N valid/ready streams into one registered output stream.
// Define POWLIB_SRRARB_IDX_EN to add the registered outidx port (source stream of the output word).
module powlib_srrarb #(
  parameter int W = 16,
  parameter int N = 4,
  localparam int WIDX = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] indata,
  input  logic [N-1:0]   invld,
  output logic [N-1:0]   inrdy,
  output logic [W-1:0]   outdata,
  output logic           outvld,
  input  logic           outrdy
`ifdef POWLIB_SRRARB_IDX_EN
  ,
  output logic [WIDX-1:0] outidx
`endif
);

  // Handshake: a word moves across an interface on a rising edge where valid and ready
  // are both 1. Valid never waits for ready; producers hold valid/data until accepted.

  logic [W-1:0]    outdata_q, outdata_d;
  logic            outvld_q, outvld_d;
  logic [WIDX-1:0] ptr_q, ptr_d;
  logic [WIDX-1:0] gnt;
  logic            gany;
  logic            ld;
  logic [W-1:0]    sel_data;

  function automatic int wrap_idx(input int a);
    return (a >= N) ? a - N : a;
  endfunction

  // Output register accepts a word when empty or draining this cycle; reset blocks inputs.
  assign ld   = rst && (!outvld_q || outrdy);
  assign gany = |invld;

  // Walk from the highest offset down so the nearest requester at or after ptr wins.
  always_comb begin
    gnt = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (invld[wrap_idx(int'(ptr_q) + k)]) begin
        gnt = WIDX'(wrap_idx(int'(ptr_q) + k));
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == WIDX'(i)) begin
        sel_data = indata[i*W +: W];
      end
    end
  end

  always_comb begin
    inrdy = '0;
    if (ld && gany) begin
      inrdy[gnt] = 1'b1;
    end
  end

  always_comb begin
    outdata_d = outdata_q;
    outvld_d  = outvld_q;
    ptr_d     = ptr_q;
    if (ld) begin
      if (gany) begin
        outdata_d = sel_data;
        outvld_d  = 1'b1;
        ptr_d     = (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
      end else begin
        outvld_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      outdata_q <= '0;
      outvld_q  <= 1'b0;
      ptr_q     <= '0;
    end else begin
      outdata_q <= outdata_d;
      outvld_q  <= outvld_d;
      ptr_q     <= ptr_d;
    end
  end

  assign outdata = outdata_q;
  assign outvld  = outvld_q;

`ifdef POWLIB_SRRARB_IDX_EN
  logic [WIDX-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q <= '0;
    end else if (ld && gany) begin
      idx_q <= gnt;
    end
  end

  assign outidx = idx_q;
`endif

endmodule

// File: tb/tb_powlib_srrarb.sv
// Directed bench for powlib_srrarb (N=4, W=16): stimulus pushes expected words, a monitor
// pops and compares every word the arbiter hands downstream.
module tb_powlib_srrarb;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] indata;
  logic [N-1:0]   invld;
  logic [N-1:0]   inrdy;
  logic [W-1:0]   outdata;
  logic           outvld;
  logic           outrdy;
`ifdef POWLIB_SRRARB_IDX_EN
  logic [1:0]     outidx;
`endif

  powlib_srrarb #(.W(W), .N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .indata  (indata),
    .invld   (invld),
    .inrdy   (inrdy),
    .outdata (outdata),
    .outvld  (outvld),
    .outrdy  (outrdy)
`ifdef POWLIB_SRRARB_IDX_EN
    ,
    .outidx  (outidx)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_idx_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] d, input logic [1:0] idx);
    exp_q.push_back(d);
    exp_idx_q.push_back(idx);
  endtask

  always @(negedge clk) begin
    if (outvld === 1'b1 && outrdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: actual=%h required=none at %0t", outdata, $time);
      end else begin
        logic [W-1:0] e;
        logic [1:0]   ei;
        e  = exp_q.pop_front();
        ei = exp_idx_q.pop_front();
        chk("out_word", outdata, e);
`ifdef POWLIB_SRRARB_IDX_EN
        chk("out_idx", outidx, ei);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) indata[i*W +: W] = base + W'(i);
  endtask

  int   seq[N];
  logic [N-1:0] acc;
  logic wr;
  int   cnt;
  bit   read_en;
  bit   rd;
  bit   done;

  task automatic drive_prod();
    for (int i = 0; i < N; i++) begin
      invld[i] = (seq[i] < 3);
      indata[i*W +: W] = 16'hD000 | W'(i << 8) | W'(seq[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b0;
    invld  = 4'hF;
    outrdy = 1'b1;
    set_data(16'h00A0);

    // reset held for 3 cycles with every stream requesting
    step();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_outvld", outvld, 1'b0);
      chk("rst_outdata", outdata, 16'h0000);
      chk("rst_inrdy", inrdy, 4'b0000);
      step();
    end

    // round robin: A0..A3 twice, no bubbles
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_exp(16'h00A0 + W'(i), 2'(i));
    rst = 1'b1;
    @(negedge clk);
    chk("first_gnt", inrdy, 4'b0001);
    for (int c = 0; c < 8; c++) begin
      step();
      chk("rr_nobubble", outvld, 1'b1);
    end
    invld = 4'b0000;
    step();
    chk("rr_idle", outvld, 1'b0);

    // priority skip: 0,1 then wrap past 2,3 back to 0
    set_data(16'h00B0);
    invld = 4'b0011;
    push_exp(16'h00B0, 2'd0);
    push_exp(16'h00B1, 2'd1);
    push_exp(16'h00B0, 2'd0);
    push_exp(16'h00B1, 2'd1);
    @(negedge clk); chk("skip_g0", inrdy, 4'b0001); step();
    @(negedge clk); chk("skip_g1", inrdy, 4'b0010); step();
    @(negedge clk); chk("skip_wrap", inrdy, 4'b0001); step();
    @(negedge clk); chk("skip_g1b", inrdy, 4'b0010); step();
    invld = 4'b0000;
    step();

    // backpressure: 1234 held for 5 cycles, then replaced in the same edge it drains
    outrdy = 1'b0;
    invld  = 4'b0100;
    indata[2*W +: W] = 16'h1234;
    push_exp(16'h1234, 2'd2);
    push_exp(16'h00C3, 2'd3);
    step();
    invld = 4'hF;
    set_data(16'h00C0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_outdata", outdata, 16'h1234);
      chk("bp_outvld", outvld, 1'b1);
      chk("bp_inrdy", inrdy, 4'b0000);
      step();
    end
    outrdy = 1'b1;
    @(negedge clk);
    chk("bp_resume_gnt", inrdy, 4'b1000);
    step();
    invld = 4'b0000;
    chk("bp_same_edge", outdata, 16'h00C3);
    step();

    // FIFO model downstream: 7 slots fill, 8th word held, then drain
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) push_exp(16'hD000 | W'(i << 8) | W'(r), 2'(i));
    for (int i = 0; i < N; i++) seq[i] = 0;
    cnt = 0; read_en = 0; rd = 0; done = 0;
    outrdy = 1'b1;
    drive_prod();
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      acc = invld & inrdy;
      wr  = outvld & outrdy;
      step();
      cnt = cnt + (wr ? 1 : 0) - (rd ? 1 : 0);
      for (int i = 0; i < N; i++) if (acc[i]) seq[i]++;
      if (c == 14) begin
        chk("fifo_fill_count", cnt, 7);
        chk("fifo_held_vld", outvld, 1'b1);
        chk("fifo_held_word", outdata, 16'hD301);
        chk("fifo_stall_inrdy", inrdy, 4'b0000);
        read_en = 1;
      end
      rd     = read_en && (cnt > 0);
      outrdy = (cnt < 7);
      drive_prod();
      if (c > 14 && exp_q.size() == 0 && outvld == 1'b0) done = 1;
    end
    chk("fifo_drained", done, 1'b1);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    n_cmp++;
    n_err++;
    $display("FAIL timeout: actual=running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
